frame_downloader: RTL and testbench
===================================

// Module: frame_downloader
// PURPOSE
//  Read side of the SDRAM frame buffer: fetches one stored RGB565 frame from SDRAM with
//  burst reads and pushes it, pixel by pixel, into the display-side store FIFO.
//  Mirrors the camera upload path: same memory command interface (cmd/cmd_en/addr/rd_data),
//  same 16-bit word addressing, same 17-bit FIFO word format (bit16 = frame-start marker).
// PARAMETERS
//  FRAME_WIDTH   480  pixels per line
//  FRAME_HEIGHT  272  lines per frame
//  MEMORY_BURST  32   burst length in bytes; fixed at 32 = 8 beats x 32 bit = 16 pixels
//  ADDR_WIDTH    21   memory word-address width (16-bit words)
// PORTS
//  clk            in   1   frame-buffer clock; all logic on rising edge
//  reset          in   1   asynchronous, active-high reset
//  init_done      in   1   SDRAM controller initialised; no command is issued while low
//  start          in   1   one-cycle pulse: begin reading a frame at base_addr
//  base_addr      in   21  frame start word address, sampled on accepted start
//  busy           out  1   high from accepted start until done
//  done           out  1   one-cycle pulse after the last pixel is written to the FIFO
//  error          out  1   sticky protocol error; cleared only by reset
//  cmd            out  1   memory command, 0 = read (this block never drives 1)
//  cmd_en         out  1   one-cycle command strobe
//  addr           out  21  burst word address, valid while cmd_en high
//  rd_data        in   32  read beat {pixel n+1, pixel n}; low half is the lower address
//  rd_data_valid  in   1   rd_data qualifier
//  store_wr_en    out  1   store FIFO write strobe
//  store_data     out  17  store FIFO word: 17'h10000 = frame marker, else {1'b0, pixel}
//  store_full     in   1   store FIFO full; no write is issued while high
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, pixel counter 0, error 0, internal buffer cleared.
//  - FSM: IDLE -> MARKER -> READ_CMD -> READ_DATA -> DRAIN -> (READ_CMD | DONE) -> IDLE.
//  - IDLE: start accepted only when init_done=1; base_addr latched, busy=1 next cycle.
//    start while busy is ignored; start with init_done=0 is ignored (busy stays 0).
//  - MARKER: writes 17'h10000 once, in the first cycle with store_full=0.
//  - READ_CMD: one-cycle cmd_en=1, cmd=0, addr = base + 16*k (k = burst index from 0).
//    Address wraps modulo 2^ADDR_WIDTH without error.
//  - READ_DATA: accepts exactly 8 valid beats into a 16x16 pixel buffer, low half first.
//    Beats may arrive with gaps; the command strobe is never reissued during this state.
//  - rd_data_valid in any other state: beat dropped, error set, FSM unaffected.
//  - DRAIN: writes buffered pixels in address order, one per cycle while store_full=0,
//    holding store_data stable across full stalls. Only valid pixels are written:
//    16 per burst except the last, which carries (W*H mod 16) pixels (16 if remainder 0).
//  - Next READ_CMD is issued only after DRAIN empties (at most one burst in flight).
//  - After the last valid pixel: DONE asserts done for 1 cycle, busy drops same cycle.
//  - Total FIFO writes per frame = 1 + W*H; bursts per frame = ceil(W*H / 16).
//  - Minimum latency start -> first cmd_en: 2 cycles (marker write, then command).
//  - init_done falling mid-frame: finish the in-flight burst, stall before next READ_CMD.
//  - reset mid-frame: immediate return to IDLE; partial frame is abandoned, no done pulse.
// TESTING
//  - 23x17 frame, base 0x30C, no stalls -> 25 read cmds at 0x30C+16k, 392 FIFO writes,
//    first 17'h10000, last burst writes 7 pixels, single done pulse, error=0.
//  - Same frame, store_full toggled randomly 50% -> identical FIFO data order, no write
//    while full, store_data stable during stalls, no cmd_en before DRAIN completes.
//  - 16x2 frame (remainder 0) -> 2 bursts, 33 FIFO writes, both bursts fully written.
//  - rd_data_valid pulsed in IDLE, then a 9th beat after a burst -> error=1 and sticky;
//    frame still completes with correct pixels.
//  - base 0x1FFFF8, 23x17 -> addresses wrap through 0x000008 with no error.
//  - reset asserted after burst 3 data, then new start -> clean frame from marker,
//    no done for the aborted frame; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/frame_downloader_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_downloader_if
//  Brief    : SDRAM read-command bus plus store-FIFO write port of the
//             frame downloader, grouped as one interface.
//  Revision : 1.0
// ============================================================================
interface frame_downloader_if #(
    parameter int ADDR_WIDTH = 21
);
    logic                  init_done;
    logic                  cmd;
    logic                  cmd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           rd_data;
    logic                  rd_data_valid;
    logic                  store_wr_en;
    logic [16:0]           store_data;
    logic                  store_full;

    modport master (
        input  init_done, rd_data, rd_data_valid, store_full,
        output cmd, cmd_en, addr, store_wr_en, store_data
    );

    modport slave (
        output init_done, rd_data, rd_data_valid, store_full,
        input  cmd, cmd_en, addr, store_wr_en, store_data
    );
endinterface
`default_nettype wire

// File: rtl/frame_downloader.sv
`default_nettype none
// ============================================================================
//  Module   : frame_downloader
//  Brief    : Fetches one RGB565 frame from SDRAM in 8-beat bursts and streams
//             it, marker first, into the display store FIFO.
//  Revision : 1.0
// ============================================================================
module frame_downloader #(
    parameter int FRAME_WIDTH  = 480,
    parameter int FRAME_HEIGHT = 272,
    parameter int MEMORY_BURST = 32,
    parameter int ADDR_WIDTH   = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    frame_downloader_if.master    bus
);
    localparam int PIX_PER_BURST = MEMORY_BURST / 2;
    localparam int BEATS         = MEMORY_BURST / 4;
    localparam int IDX_W         = $clog2(PIX_PER_BURST);
    localparam int BEAT_W        = $clog2(BEATS);
    localparam int TOTAL         = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int CNT_W         = ($clog2(TOTAL + 1) > IDX_W) ? $clog2(TOTAL + 1) : IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TOTAL - 1);
    localparam logic [16:0]      MARKER   = 17'h10000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MARKER    = 3'd1,
        S_READ_CMD  = 3'd2,
        S_READ_DATA = 3'd3,
        S_DRAIN     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      pix_cnt_q;
    logic [CNT_W-1:0]      pix_cnt_d;
    logic [BEAT_W-1:0]     beat_q;
    logic [15:0]           buf_q [PIX_PER_BURST];
    logic [16:0]           data_q;
    logic                  valid_q;
    logic                  cmd_en_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic                  wr_fire;

    // data_q/valid_q hold the pending FIFO word; the strobe is gated by full
    // so a word is never offered while the FIFO cannot take it.
    assign wr_fire   = valid_q & ~bus.store_full;
    assign pix_cnt_d = pix_cnt_q + CNT_W'(1);

    assign bus.cmd         = 1'b0;
    assign bus.cmd_en      = cmd_en_q;
    assign bus.addr        = addr_q;
    assign bus.store_wr_en = wr_fire;
    assign bus.store_data  = data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            pix_cnt_q <= '0;
            beat_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            cmd_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            for (int i = 0; i < PIX_PER_BURST; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            if (bus.rd_data_valid && (state_q != S_READ_DATA)) begin
                error_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i && bus.init_done) begin
                        base_q    <= base_addr_i;
                        busy_q    <= 1'b1;
                        pix_cnt_q <= '0;
                        beat_q    <= '0;
                        data_q    <= MARKER;
                        valid_q   <= 1'b1;
                        state_q   <= S_MARKER;
                    end
                end
                S_MARKER: begin
                    if (wr_fire) begin
                        valid_q  <= 1'b0;
                        addr_q   <= base_q;
                        cmd_en_q <= bus.init_done;
                        state_q  <= S_READ_CMD;
                    end
                end
                S_READ_CMD: begin
                    // Waits here with the address ready while init_done is low.
                    if (cmd_en_q) begin
                        cmd_en_q <= 1'b0;
                        state_q  <= S_READ_DATA;
                    end else if (bus.init_done) begin
                        cmd_en_q <= 1'b1;
                    end
                end
                S_READ_DATA: begin
                    if (bus.rd_data_valid) begin
                        buf_q[{beat_q, 1'b0}] <= bus.rd_data[15:0];
                        buf_q[{beat_q, 1'b1}] <= bus.rd_data[31:16];
                        beat_q                <= beat_q + BEAT_W'(1);
                        if (beat_q == BEAT_W'(BEATS - 1)) begin
                            data_q  <= {1'b0, buf_q[0]};
                            valid_q <= 1'b1;
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (wr_fire) begin
                        pix_cnt_q <= pix_cnt_d;
                        if (pix_cnt_q == LAST_PIX) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (pix_cnt_d[IDX_W-1:0] == '0) begin
                            valid_q  <= 1'b0;
                            addr_q   <= base_q + ADDR_WIDTH'(pix_cnt_d);
                            cmd_en_q <= bus.init_done;
                            state_q  <= S_READ_CMD;
                        end else begin
                            data_q <= {1'b0, buf_q[pix_cnt_d[IDX_W-1:0]]};
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_frame_downloader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_downloader
//  Brief    : Self-checking bench: SDRAM burst responder, store-FIFO monitor and
//             a frame-level reference model for two frame geometries.
//  Revision : 1.0
// ============================================================================
module tb_frame_downloader;
    localparam int AW = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, sel, start, init_done, rd_valid, stray, store_full, full_rand, clr_req;
    logic [31:0]   rd_data;
    logic [AW-1:0] base;
    logic          busy_a, done_a, err_a, busy_b, done_b, err_b;
    int            n_tests, n_fail, W, H, extra_burst, maxgap;

    frame_downloader_if #(.ADDR_WIDTH(AW)) bus_a ();
    frame_downloader_if #(.ADDR_WIDTH(AW)) bus_b ();

    assign bus_a.init_done     = init_done;
    assign bus_a.rd_data       = rd_data;
    assign bus_a.rd_data_valid = (rd_valid | stray) & ~sel;
    assign bus_a.store_full    = store_full;
    assign bus_b.init_done     = init_done;
    assign bus_b.rd_data       = rd_data;
    assign bus_b.rd_data_valid = (rd_valid | stray) & sel;
    assign bus_b.store_full    = store_full;

    frame_downloader #(.FRAME_WIDTH(23), .FRAME_HEIGHT(17), .MEMORY_BURST(32), .ADDR_WIDTH(AW)) dut_a (
        .clk(clk), .reset(reset), .start_i(start & ~sel), .base_addr_i(base),
        .busy_o(busy_a), .done_o(done_a), .error_o(err_a), .bus(bus_a));

    frame_downloader #(.FRAME_WIDTH(16), .FRAME_HEIGHT(2), .MEMORY_BURST(32), .ADDR_WIDTH(AW)) dut_b (
        .clk(clk), .reset(reset), .start_i(start & sel), .base_addr_i(base),
        .busy_o(busy_b), .done_o(done_b), .error_o(err_b), .bus(bus_b));

    logic          m_cmd, m_cmd_en, m_wr_en, m_busy, m_done;
    logic [AW-1:0] m_addr;
    logic [16:0]   m_store_data;
    assign m_cmd        = sel ? bus_b.cmd         : bus_a.cmd;
    assign m_cmd_en     = sel ? bus_b.cmd_en      : bus_a.cmd_en;
    assign m_addr       = sel ? bus_b.addr        : bus_a.addr;
    assign m_wr_en      = sel ? bus_b.store_wr_en : bus_a.store_wr_en;
    assign m_store_data = sel ? bus_b.store_data  : bus_a.store_data;
    assign m_busy       = sel ? busy_b            : busy_a;
    assign m_done       = sel ? done_b            : done_a;

    // Memory contents: a scrambled function of the word address.
    function automatic logic [15:0] pix(input logic [AW-1:0] a);
        logic [15:0] m;
        m = 16'(a[15:0] * 16'd40503);
        return m ^ {11'd0, a[20:16]} ^ 16'h5A5A;
    endfunction

    // ---------------- monitor (owns the logs) ----------------
    logic [16:0]   got[$];
    logic [AW-1:0] cmds[$];
    int            done_cnt, full_viol, drain_viol, busy_done_viol;

    always @(negedge clk) begin
        if (clr_req) begin
            got.delete(); cmds.delete();
            done_cnt = 0; full_viol = 0; drain_viol = 0; busy_done_viol = 0;
        end else begin
            if (m_wr_en) begin
                if (store_full) full_viol++;
                got.push_back(m_store_data);
            end
            if (m_cmd_en) begin
                if (m_cmd !== 1'b0 || got.size() != 1 + 16 * cmds.size()) drain_viol++;
                cmds.push_back(m_addr);
            end
            if (m_done) begin
                done_cnt++;
                if (m_busy) busy_done_viol++;
            end
        end
    end

    // ---------------- SDRAM burst responder ----------------
    int            bursts_delivered;
    initial begin
        logic          active;
        logic [AW-1:0] a_cur, lo;
        int            beat, gap, nbeats;
        rd_valid = 1'b0; rd_data = '0; bursts_delivered = 0; active = 1'b0;
        a_cur = '0; beat = 0; gap = 0; nbeats = 8;
        forever begin
            @(posedge clk); #1;
            rd_valid = 1'b0;
            if (clr_req) bursts_delivered = 0;
            if (reset) begin
                active = 1'b0;
            end else if (active) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    lo      = a_cur + AW'(2 * beat);
                    rd_data = {pix(lo + AW'(1)), pix(lo)};
                    rd_valid = 1'b1;
                    beat++;
                    gap = $urandom_range(0, maxgap);
                    if (beat == nbeats) begin
                        active = 1'b0;
                        bursts_delivered++;
                    end
                end
            end else if (m_cmd_en) begin
                active = 1'b1; a_cur = m_addr; beat = 0;
                gap    = $urandom_range(0, maxgap);
                nbeats = (bursts_delivered == extra_burst) ? 9 : 8;
            end
        end
    end

    initial begin
        store_full = 1'b0;
        forever begin
            @(posedge clk); #1;
            store_full = full_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // ---------------- reference model ----------------
    function automatic int data_errs(input logic [AW-1:0] b);
        int e, n;
        logic [16:0] ex;
        e = 0; n = 1 + W * H;
        for (int i = 0; i < n; i++) begin
            ex = (i == 0) ? 17'h10000 : {1'b0, pix(b + AW'(i - 1))};
            if (i >= got.size() || got[i] !== ex) e++;
        end
        if (got.size() > n) e += got.size() - n;
        return e;
    endfunction

    function automatic int cmd_errs(input logic [AW-1:0] b);
        int e, nb;
        logic [AW-1:0] ex;
        e = 0; nb = (W * H + 15) / 16;
        for (int k = 0; k < nb; k++) begin
            ex = b + AW'(16 * k);
            if (k >= cmds.size() || cmds[k] !== ex) e++;
        end
        if (cmds.size() > nb) e += cmds.size() - nb;
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        clr_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        clr_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic start_frame(input logic [AW-1:0] b, output int lat);
        @(posedge clk); #1;
        base = b; start = 1'b1; lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (m_cmd_en) break;
        end
    endtask

    task automatic wait_frame(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk); #1;
        n_tests++;
        if ({busy_a, done_a, err_a, bus_a.cmd_en, bus_a.store_wr_en} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl_a: got %b expected 00000", {busy_a, done_a, err_a, bus_a.cmd_en, bus_a.store_wr_en});
        end
        n_tests++;
        if (bus_a.addr !== '0 || bus_a.store_data !== '0 || bus_a.cmd !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus_a: got addr %h data %h expected 0", bus_a.addr, bus_a.store_data);
        end
        n_tests++;
        if ({busy_b, done_b, err_b, bus_b.cmd_en, bus_b.store_wr_en} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl_b: got %b expected 00000", {busy_b, done_b, err_b, bus_b.cmd_en, bus_b.store_wr_en});
        end
    endtask

    task automatic test_no_stall();
        int lat; bit ok;
        sel = 1'b0; W = 23; H = 17; full_rand = 1'b0; maxgap = 2;
        clear_logs();
        start_frame(21'h30C, lat);
        wait_frame(20000, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL nostall_timeout: got no done, expected done"); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL start_latency: got %0d expected 2", lat); end
        n_tests++; if (cmds.size() !== 25) begin n_fail++; $display("FAIL nostall_cmds: got %0d expected 25", cmds.size()); end
        n_tests++; if (cmd_errs(21'h30C) !== 0) begin n_fail++; $display("FAIL nostall_addr: got %0d bad expected 0", cmd_errs(21'h30C)); end
        n_tests++; if (got.size() !== 392) begin n_fail++; $display("FAIL nostall_writes: got %0d expected 392", got.size()); end
        n_tests++; if (data_errs(21'h30C) !== 0) begin n_fail++; $display("FAIL nostall_data: got %0d bad expected 0", data_errs(21'h30C)); end
        n_tests++; if (got.size() - 1 - 16 * 24 !== 7) begin n_fail++; $display("FAIL last_burst_pixels: got %0d expected 7", got.size() - 1 - 16 * 24); end
        n_tests++; if (done_cnt !== 1 || busy_done_viol !== 0) begin n_fail++; $display("FAIL nostall_done: got %0d pulses (%0d with busy) expected 1 (0)", done_cnt, busy_done_viol); end
        n_tests++; if (err_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL nostall_flags: got err %b busy %b expected 0 0", err_a, busy_a); end
        n_tests++; if (drain_viol !== 0) begin n_fail++; $display("FAIL nostall_cmd_order: got %0d expected 0", drain_viol); end
    endtask

    task automatic test_stall();
        int lat; bit ok;
        sel = 1'b0; W = 23; H = 17; maxgap = 3;
        clear_logs();
        full_rand = 1'b1;
        start_frame(21'h30C, lat);
        wait_frame(30000, ok);
        full_rand = 1'b0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no done, expected done"); end
        n_tests++; if (data_errs(21'h30C) !== 0) begin n_fail++; $display("FAIL stall_data: got %0d bad expected 0", data_errs(21'h30C)); end
        n_tests++; if (full_viol !== 0) begin n_fail++; $display("FAIL stall_write_while_full: got %0d expected 0", full_viol); end
        n_tests++; if (drain_viol !== 0) begin n_fail++; $display("FAIL stall_cmd_before_drain: got %0d expected 0", drain_viol); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL stall_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_exact_burst();
        int lat; bit ok; logic [AW-1:0] b;
        sel = 1'b1; W = 16; H = 2; maxgap = 2;
        b = AW'($urandom);
        clear_logs();
        start_frame(b, lat);
        wait_frame(5000, ok);
        n_tests++; if (!ok || done_cnt !== 1) begin n_fail++; $display("FAIL exact_done: got %0d expected 1", done_cnt); end
        n_tests++; if (cmds.size() !== 2 || cmd_errs(b) !== 0) begin n_fail++; $display("FAIL exact_cmds: got %0d cmds expected 2", cmds.size()); end
        n_tests++; if (got.size() !== 33) begin n_fail++; $display("FAIL exact_writes: got %0d expected 33", got.size()); end
        n_tests++; if (data_errs(b) !== 0 || err_b !== 1'b0) begin n_fail++; $display("FAIL exact_data: got %0d bad err %b expected 0 0", data_errs(b), err_b); end
        sel = 1'b0;
    endtask

    task automatic test_error();
        int lat; bit ok; logic [AW-1:0] b;
        sel = 1'b0; W = 23; H = 17; maxgap = 1;
        do_reset();
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_tests++; if (err_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL idle_beat_error: got err %b busy %b expected 1 0", err_a, busy_a); end
        do_reset();
        n_tests++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL error_reset: got %b expected 0", err_a); end
        b = AW'($urandom);
        clear_logs();
        extra_burst = 0;
        start_frame(b, lat);
        wait_frame(20000, ok);
        extra_burst = -1;
        n_tests++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL ninth_beat_error: got %b expected 1", err_a); end
        n_tests++; if (!ok || data_errs(b) !== 0) begin n_fail++; $display("FAIL error_frame_data: got %0d bad expected 0", data_errs(b)); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL error_frame_done: got %0d expected 1", done_cnt); end
        do_reset();
    endtask

    task automatic test_wrap();
        int lat; bit ok;
        sel = 1'b0; W = 23; H = 17; maxgap = 2;
        clear_logs();
        start_frame(21'h1FFFF8, lat);
        wait_frame(20000, ok);
        n_tests++; if (!ok || cmd_errs(21'h1FFFF8) !== 0) begin n_fail++; $display("FAIL wrap_addr: got %0d bad expected 0", cmd_errs(21'h1FFFF8)); end
        n_tests++; if (cmds.size() < 2 || cmds[1] !== 21'h000008) begin n_fail++; $display("FAIL wrap_second_cmd: got %h expected 000008", (cmds.size() > 1) ? cmds[1] : '1); end
        n_tests++; if (data_errs(21'h1FFFF8) !== 0 || err_a !== 1'b0) begin n_fail++; $display("FAIL wrap_data: got %0d bad err %b expected 0 0", data_errs(21'h1FFFF8), err_a); end
    endtask

    task automatic test_abort_restart();
        int lat; bit ok; logic [AW-1:0] b1, b2;
        sel = 1'b0; W = 23; H = 17; maxgap = 2;
        b1 = AW'($urandom); b2 = AW'($urandom);
        clear_logs();
        start_frame(b1, lat);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (bursts_delivered >= 3) begin ok = 1'b1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_wait: got %0d bursts expected 3", bursts_delivered); end
        do_reset();
        n_tests++; if (busy_a !== 1'b0 || done_cnt !== 0) begin n_fail++; $display("FAIL abort_state: got busy %b done %0d expected 0 0", busy_a, done_cnt); end
        clear_logs();
        start_frame(b2, lat);
        repeat (5) @(posedge clk);
        #1 base = ~b2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_frame(20000, ok);
        n_tests++; if (!ok || data_errs(b2) !== 0) begin n_fail++; $display("FAIL restart_data: got %0d bad expected 0", data_errs(b2)); end
        n_tests++; if (done_cnt !== 1 || cmd_errs(b2) !== 0) begin n_fail++; $display("FAIL restart_done: got %0d pulses %0d bad cmds expected 1 0", done_cnt, cmd_errs(b2)); end
    endtask

    task automatic test_init_done();
        int lat; bit ok; logic [AW-1:0] b;
        sel = 1'b0; W = 23; H = 17; maxgap = 2;
        b = AW'($urandom);
        clear_logs();
        init_done = 1'b0;
        @(posedge clk); #1 base = b; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk); #1;
        n_tests++; if (busy_a !== 1'b0 || cmds.size() !== 0) begin n_fail++; $display("FAIL no_init_start: got busy %b cmds %0d expected 0 0", busy_a, cmds.size()); end
        init_done = 1'b1;
        start_frame(b, lat);
        init_done = 1'b0;
        repeat (80) @(posedge clk); #1;
        n_tests++; if (cmds.size() !== 1 || got.size() !== 17 || busy_a !== 1'b1) begin
            n_fail++; $display("FAIL init_stall: got cmds %0d writes %0d busy %b expected 1 17 1", cmds.size(), got.size(), busy_a);
        end
        init_done = 1'b1;
        wait_frame(20000, ok);
        n_tests++; if (!ok || data_errs(b) !== 0 || cmds.size() !== 25) begin n_fail++; $display("FAIL init_resume: got %0d bad %0d cmds expected 0 25", data_errs(b), cmds.size()); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; W = 23; H = 17; extra_burst = -1; maxgap = 0;
        reset = 1'b1; sel = 1'b0; start = 1'b0; base = '0; init_done = 1'b1;
        stray = 1'b0; full_rand = 1'b0; clr_req = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        #1 reset = 1'b0;
        test_reset();
        test_no_stall();
        test_stall();
        test_exact_burst();
        test_error();
        test_wrap();
        test_abort_restart();
        test_init_done();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
